// File: rtl/tdc_pulse_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_pulse_gen_if
//  Description : Control/status bundle of the TDC START pulse generator.
//                master : the controller that requests pulses and watches
//                         status.
//                slave  : the pulse generator itself.
//  Signals     : go, abort, width_coarse, width_fine, gap, burst_len  (to gen)
//                pulse_out, arm_out, fine_sel, busy, done, pulses_sent (from)
//  Revision    : 1.0 - initial release
// ============================================================================
interface tdc_pulse_gen_if #(
    parameter int COARSE_W = 29,
    parameter int FINE_W   = 5,
    parameter int GAP_W    = 16,
    parameter int CNT_W    = 8
);
    logic                go;
    logic                abort;
    logic [COARSE_W-1:0] width_coarse;
    logic [FINE_W-1:0]   width_fine;
    logic [GAP_W-1:0]    gap;
    logic [CNT_W-1:0]    burst_len;
    logic                pulse_out;
    logic                arm_out;
    logic [FINE_W-1:0]   fine_sel;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    pulses_sent;

    modport master (
        output go, abort, width_coarse, width_fine, gap, burst_len,
        input  pulse_out, arm_out, fine_sel, busy, done, pulses_sent
    );

    modport slave (
        input  go, abort, width_coarse, width_fine, gap, burst_len,
        output pulse_out, arm_out, fine_sel, busy, done, pulses_sent
    );
endinterface
`default_nettype wire

// File: rtl/tdc_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_pulse_gen
//  Description : Programmable START pulse generator for the TDC self-test
//                path. Emits a one-cycle arm strobe, then a pulse of W
//                cycles, repeated N times with G low cycles in between.
//                A fine delay-tap code is latched on go and held.
//  Ports       : clk  - 200 MHz clock
//                rst  - synchronous active-high reset
//                bus  - tdc_pulse_gen_if.slave (request inputs, status outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module tdc_pulse_gen #(
    parameter int COARSE_W = 29,
    parameter int FINE_W   = 5,
    parameter int GAP_W    = 16,
    parameter int CNT_W    = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    tdc_pulse_gen_if.slave      bus
);

    // One down-counter serves both the high and the gap phase, so it must
    // hold the wider of the two fields.
    localparam int c_CTR_W = (COARSE_W > GAP_W) ? COARSE_W : GAP_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]          r_state;
    logic [c_CTR_W-1:0]  r_cnt;
    logic [COARSE_W-1:0] r_w;
    logic [GAP_W-1:0]    r_g;
    logic [CNT_W-1:0]    r_n;
    logic [CNT_W-1:0]    r_pulses_sent;
    logic [FINE_W-1:0]   r_fine_sel;
    logic                r_pulse_out;
    logic                r_arm_out;
    logic                r_busy;
    logic                r_done;

    logic [COARSE_W-1:0] w_w_clamped;
    logic [GAP_W-1:0]    w_g_clamped;
    logic [CNT_W-1:0]    w_n_clamped;
    logic [CNT_W-1:0]    w_sent_next;

    // Minimum gap of 4 cycles gives the TDC time to finish and re-arm.
    assign w_w_clamped = (bus.width_coarse == '0) ? COARSE_W'(1) : bus.width_coarse;
    assign w_g_clamped = (bus.gap < GAP_W'(4))    ? GAP_W'(4)    : bus.gap;
    assign w_n_clamped = (bus.burst_len == '0)    ? CNT_W'(1)    : bus.burst_len;

    // pulses_sent is always below N while a pulse is in flight, so this
    // increment cannot overflow and the count naturally stops at N.
    assign w_sent_next = r_pulses_sent + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_w           <= '0;
            r_g           <= '0;
            r_n           <= '0;
            r_pulses_sent <= '0;
            r_fine_sel    <= '0;
            r_pulse_out   <= 1'b0;
            r_arm_out     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state != S_IDLE) && bus.abort) begin
                // A pulse cut short here is not counted; done stays low.
                r_state     <= S_IDLE;
                r_pulse_out <= 1'b0;
                r_arm_out   <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.go && !bus.abort) begin
                            r_w           <= w_w_clamped;
                            r_g           <= w_g_clamped;
                            r_n           <= w_n_clamped;
                            r_fine_sel    <= bus.width_fine;
                            r_pulses_sent <= '0;
                            r_busy        <= 1'b1;
                            r_arm_out     <= 1'b1;
                            r_state       <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        r_arm_out   <= 1'b0;
                        r_pulse_out <= 1'b1;
                        r_cnt       <= c_CTR_W'(r_w);
                        r_state     <= S_HIGH;
                    end
                    S_HIGH: begin
                        // Counter was loaded with W at the rising edge, so
                        // seeing 1 here means W high cycles have elapsed.
                        if (r_cnt == c_CTR_W'(1)) begin
                            r_pulse_out   <= 1'b0;
                            r_pulses_sent <= w_sent_next;
                            if (w_sent_next == r_n) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_cnt   <= c_CTR_W'(r_g);
                                r_state <= S_GAP;
                            end
                        end else begin
                            r_cnt <= r_cnt - c_CTR_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (r_cnt == c_CTR_W'(1)) begin
                            r_arm_out <= 1'b1;
                            r_state   <= S_ARM;
                        end else begin
                            r_cnt <= r_cnt - c_CTR_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.pulse_out   = r_pulse_out;
    assign bus.arm_out     = r_arm_out;
    assign bus.fine_sel    = r_fine_sel;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pulses_sent = r_pulses_sent;

endmodule
`default_nettype wire

// File: tb/tb_tdc_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdc_pulse_gen
//  Description : Directed self-checking bench for tdc_pulse_gen. Per-cycle
//                traces of a burst are packed into bit vectors (bit m is the
//                value seen just after edge k+m) and compared against
//                hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_pulse_gen;

    localparam int COARSE_W = 29;
    localparam int FINE_W   = 5;
    localparam int GAP_W    = 16;
    localparam int CNT_W    = 8;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] cap_pulse;
    logic [63:0] cap_arm;
    logic [63:0] cap_done;
    logic [63:0] cap_busy;

    tdc_pulse_gen_if #(
        .COARSE_W (COARSE_W),
        .FINE_W   (FINE_W),
        .GAP_W    (GAP_W),
        .CNT_W    (CNT_W)
    ) bus ();

    tdc_pulse_gen #(
        .COARSE_W (COARSE_W),
        .FINE_W   (FINE_W),
        .GAP_W    (GAP_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requests a burst and records len cycles starting at the acceptance edge.
    // With perturb set, request fields are changed and go is re-pulsed while
    // the burst is running.
    task automatic run_burst(input logic [COARSE_W-1:0] w, input logic [GAP_W-1:0] g,
                             input logic [CNT_W-1:0] n, input logic [FINE_W-1:0] f,
                             input int len, input bit perturb);
        bus.width_coarse = w;
        bus.gap          = g;
        bus.burst_len    = n;
        bus.width_fine   = f;
        bus.go           = 1'b1;
        cap_pulse = '0;
        cap_arm   = '0;
        cap_done  = '0;
        cap_busy  = '0;
        for (int m = 0; m < len; m++) begin
            tick();
            cap_pulse[m] = bus.pulse_out;
            cap_arm[m]   = bus.arm_out;
            cap_done[m]  = bus.done;
            cap_busy[m]  = bus.busy;
            bus.go = 1'b0;
            if (perturb && m == 2) begin
                bus.width_coarse = 29'd17;
                bus.width_fine   = 5'd3;
                bus.gap          = 16'd100;
                bus.burst_len    = 8'd1;
            end
            if (perturb && m == 3) bus.go = 1'b1;
        end
    endtask

    logic seen_bad;

    initial begin
        rst              = 1'b1;
        bus.go           = 1'b0;
        bus.abort        = 1'b0;
        bus.width_coarse = '0;
        bus.width_fine   = '0;
        bus.gap          = '0;
        bus.burst_len    = '0;
        tick();
        tick();
        check("reset_outputs",
              {58'd0, bus.pulse_out, bus.arm_out, bus.busy, bus.done, 2'b00}, 64'd0);
        check("reset_fine_sel", 64'(bus.fine_sel), 64'd0);
        check("reset_pulses_sent", 64'(bus.pulses_sent), 64'd0);
        rst = 1'b0;
        tick();

        // Single pulse W=10 G=8 N=1 fine=7
        run_burst(29'd10, 16'd8, 8'd1, 5'd7, 20, 1'b0);
        check("single_pulse", cap_pulse, 64'h7FE);
        check("single_arm",   cap_arm,   64'h1);
        check("single_done",  cap_done,  64'h800);
        check("single_busy",  cap_busy,  64'h7FF);
        check("single_fine_sel", 64'(bus.fine_sel), 64'd7);
        check("single_pulses_sent", 64'(bus.pulses_sent), 64'd1);

        // Burst W=5 G=4 N=3 with mid-burst field changes and a go while busy
        run_burst(29'd5, 16'd4, 8'd3, 5'd9, 40, 1'b1);
        check("burst_pulse", cap_pulse, 64'h3E0F83E);
        check("burst_arm",   cap_arm,   64'h100401);
        check("burst_done",  cap_done,  64'h4000000);
        check("burst_busy",  cap_busy,  64'h3FFFFFF);
        check("burst_pulses_sent", 64'(bus.pulses_sent), 64'd3);
        check("burst_fine_sel_held", 64'(bus.fine_sel), 64'd9);

        // Clamping W=0 G=0 N=0 -> W=1 G=4 N=1; then N=2
        run_burst(29'd0, 16'd0, 8'd0, 5'd1, 8, 1'b0);
        check("clamp_n0_pulse", cap_pulse, 64'h2);
        check("clamp_n0_done",  cap_done,  64'h4);
        run_burst(29'd0, 16'd0, 8'd2, 5'd1, 16, 1'b0);
        check("clamp_pulse", cap_pulse, 64'h82);
        check("clamp_arm",   cap_arm,   64'h41);
        check("clamp_done",  cap_done,  64'h100);
        check("clamp_pulses_sent", 64'(bus.pulses_sent), 64'd2);

        // go together with abort in IDLE: nothing starts
        bus.width_coarse = 29'd3;
        bus.burst_len    = 8'd1;
        bus.go           = 1'b1;
        bus.abort        = 1'b1;
        tick();
        bus.go    = 1'b0;
        bus.abort = 1'b0;
        check("go_abort_idle", {62'd0, bus.busy, bus.arm_out}, 64'd0);
        tick();
        check("go_abort_idle_after", {62'd0, bus.busy, bus.pulse_out}, 64'd0);

        // Abort W=20 G=4 N=2, abort driven during cycle k+5
        bus.width_coarse = 29'd20;
        bus.gap          = 16'd4;
        bus.burst_len    = 8'd2;
        bus.width_fine   = 5'd2;
        bus.go           = 1'b1;
        tick();                              // edge k
        bus.go = 1'b0;
        seen_bad = 1'b0;
        for (int m = 1; m <= 5; m++) begin
            tick();
            seen_bad = seen_bad | bus.done;
        end
        check("abort_pulse_before", 64'(bus.pulse_out), 64'd1);
        bus.abort = 1'b1;
        tick();                              // edge k+6
        bus.abort = 1'b0;
        check("abort_pulse_low", {62'd0, bus.pulse_out, bus.busy}, 64'd0);
        check("abort_pulses_sent", 64'(bus.pulses_sent), 64'd0);
        bus.width_coarse = 29'd3;
        bus.burst_len    = 8'd1;
        bus.go           = 1'b1;
        tick();                              // edge k+7
        bus.go = 1'b0;
        seen_bad = seen_bad | bus.done;
        check("abort_done_never", 64'(seen_bad), 64'd0);
        check("abort_new_go", {62'd0, bus.busy, bus.arm_out}, 64'h3);
        cap_done = '0;
        for (int m = 1; m <= 8; m++) begin
            tick();
            cap_done[m] = bus.done;
        end
        check("abort_new_done", cap_done, 64'h10);

        // Reset mid-burst W=10 G=4 N=2 fine=21
        run_burst(29'd10, 16'd4, 8'd2, 5'd21, 5, 1'b0);
        check("reset_pre_pulse", 64'(bus.pulse_out), 64'd1);
        rst = 1'b1;
        tick();
        check("midreset_outputs",
              {58'd0, bus.pulse_out, bus.arm_out, bus.busy, bus.done, 2'b00}, 64'd0);
        check("midreset_fine_sel", 64'(bus.fine_sel), 64'd0);
        tick();
        rst = 1'b0;
        seen_bad = 1'b0;
        for (int m = 0; m < 30; m++) begin
            tick();
            seen_bad = seen_bad | bus.done | bus.pulse_out | bus.busy;
        end
        check("midreset_quiet", 64'(seen_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
